// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg -- shared types and defaults for univ_shift_counter.
//
// Contents:
//   op_mode_t        3-bit operation select used by the counter and shift unit
//   DEF_N            default register width
//   DEF_RST_VAL      default reset value (sliced to N bits by the users)
//   is_left_op()     true for operations that move bits toward the MSB
//   is_right_op()    true for operations that move bits toward the LSB
package univ_shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    UP   = 3'd1,
    DOWN = 3'd2,
    SHL  = 3'd3,
    SHR  = 3'd4,
    ROL  = 3'd5,
    ROR  = 3'd6,
    ASR  = 3'd7
  } op_mode_t;

  localparam int          DEF_N       = 8;
  localparam logic [31:0] DEF_RST_VAL = '0;

  function automatic logic is_left_op(input op_mode_t m);
    return (m == SHL) || (m == ROL);
  endfunction

  function automatic logic is_right_op(input op_mode_t m);
    return (m == SHR) || (m == ROR) || (m == ASR);
  endfunction

endpackage

// File: rtl/univ_shift_counter_shift_unit.sv
// shift_unit -- combinational next-value generator for the shift and
// rotate operations of univ_shift_counter.
//
// Ports:
//   q         in   N  current register value
//   mode      in   3  operation select (op_mode_t)
//   ser_in_l  in   1  serial bit entering at the MSB on SHR
//   ser_in_r  in   1  serial bit entering at the LSB on SHL
//   shift_q   out  N  shifted/rotated value; equals q for non-shift modes
//
// Every bit takes either its lower neighbour (left moves), its upper
// neighbour (right moves) or itself. Only the two edge bits need a mode
// dependent fill value.
module shift_unit
  import univ_shift_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] q,
  input  op_mode_t     mode,
  input  logic         ser_in_l,
  input  logic         ser_in_r,
  output logic [N-1:0] shift_q
);

  logic         fill_lsb;
  logic         fill_msb;
  logic         move_left;
  logic         move_right;
  logic [N-1:0] from_below;
  logic [N-1:0] from_above;

  // Bit entering the LSB on a left move: rotate recycles the MSB.
  assign fill_lsb = (mode == ROL) ? q[N-1] : ser_in_r;

  // Bit entering the MSB on a right move.
  always_comb begin
    fill_msb = ser_in_l;
    case (mode)
      ROR:     fill_msb = q[0];
      ASR:     fill_msb = q[N-1];
      default: fill_msb = ser_in_l;
    endcase
  end

  assign move_left  = is_left_op(mode);
  assign move_right = is_right_op(mode);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign from_below[gi] = fill_lsb;
    end else begin : g_lsb_n
      assign from_below[gi] = q[gi-1];
    end

    if (gi == N - 1) begin : g_msb
      assign from_above[gi] = fill_msb;
    end else begin : g_msb_n
      assign from_above[gi] = q[gi+1];
    end

    assign shift_q[gi] = move_left  ? from_below[gi] :
                         move_right ? from_above[gi] : q[gi];
  end

endmodule

// File: rtl/univ_shift_counter.sv
// univ_shift_counter -- N-bit register that counts up/down modulo a live
// terminal value, shifts, rotates, loads and clears.
//
// Parameters:
//   N        register width, 2..32
//   RST_VAL  value loaded into q by rst
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset (q=RST_VAL, wrap=0)
//   syn_clr    in   1  synchronous clear (q=0, wrap=0)
//   load       in   1  parallel load of d
//   en         in   1  enable the operation selected by mode
//   mode       in   3  op_mode_t operation select
//   d          in   N  parallel load data
//   max_val    in   N  counter terminal value, range 0..max_val
//   ser_in_l   in   1  serial input at MSB (SHR)
//   ser_in_r   in   1  serial input at LSB (SHL)
//   sat        in   1  saturate instead of wrap (only with
//                      UNIV_SHIFT_COUNTER_SAT_EN defined)
//   q          out  N  register value
//   ser_out_l  out  1  q[N-1]
//   ser_out_r  out  1  q[0]
//   tc         out  1  terminal count for the current q and mode
//   wrap       out  1  registered pulse in the cycle after a counter wrap
//
// Priority per edge: rst > syn_clr > load > en.
module univ_shift_counter
  import univ_shift_pkg::*;
#(
  parameter int          N       = DEF_N,
  parameter logic [N-1:0] RST_VAL = DEF_RST_VAL[N-1:0]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  op_mode_t     mode,
  input  logic [N-1:0] d,
  input  logic [N-1:0] max_val,
  input  logic         ser_in_l,
  input  logic         ser_in_r,
`ifdef UNIV_SHIFT_COUNTER_SAT_EN
  input  logic         sat,
`endif
  output logic [N-1:0] q,
  output logic         ser_out_l,
  output logic         ser_out_r,
  output logic         tc,
  output logic         wrap
);

  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ZERO = '0;

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;
  logic         wrap_reg;
  logic         wrap_next;
  logic [N-1:0] shift_q;
  logic         sat_on;

`ifdef UNIV_SHIFT_COUNTER_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  shift_unit #(
    .N(N)
  ) u_shift_unit (
    .q        (q_reg),
    .mode     (mode),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .shift_q  (shift_q)
  );

  // Next-state selection below reset; wrap defaults to 0 so that any
  // cycle that does not wrap (clear, load, hold, shift) drops the pulse.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (syn_clr) begin
      q_next = ZERO;
    end else if (load) begin
      q_next = d;
    end else if (en) begin
      case (mode)
        HOLD: q_next = q_reg;
        UP: begin
          // >= rather than == so a loaded value above max_val still wraps,
          // and max_val=0 pins q at 0 with a wrap every enabled cycle.
          if (q_reg >= max_val) begin
            if (sat_on) begin
              q_next = max_val;
            end else begin
              q_next    = ZERO;
              wrap_next = 1'b1;
            end
          end else begin
            q_next = q_reg + ONE;
          end
        end
        DOWN: begin
          if (q_reg == ZERO) begin
            if (sat_on) begin
              q_next = ZERO;
            end else begin
              q_next    = max_val;
              wrap_next = 1'b1;
            end
          end else begin
            q_next = q_reg - ONE;
          end
        end
        default: q_next = shift_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= RST_VAL;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q         = q_reg;
  assign wrap      = wrap_reg;
  assign ser_out_l = q_reg[N-1];
  assign ser_out_r = q_reg[0];
  assign tc        = ((mode == UP) && (q_reg == max_val)) ||
                     ((mode == DOWN) && (q_reg == ZERO));

endmodule

// File: tb/tb_univ_shift_counter.sv
// tb_univ_shift_counter -- directed self-checking bench for
// univ_shift_counter at N=8 with RST_VAL=8'h3C (distinct from the clear
// value). Define UNIV_SHIFT_COUNTER_SAT_EN to exercise the sat port.
module tb_univ_shift_counter;
  import univ_shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       syn_clr;
  logic       load;
  logic       en;
  op_mode_t   mode;
  logic [7:0] d;
  logic [7:0] max_val;
  logic       ser_in_l;
  logic       ser_in_r;
`ifdef UNIV_SHIFT_COUNTER_SAT_EN
  logic       sat;
`endif
  logic [7:0] q;
  logic       ser_out_l;
  logic       ser_out_r;
  logic       tc;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  univ_shift_counter #(
    .N       (8),
    .RST_VAL (8'h3C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .syn_clr   (syn_clr),
    .load      (load),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .max_val   (max_val),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
`ifdef UNIV_SHIFT_COUNTER_SAT_EN
    .sat       (sat),
`endif
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .tc        (tc),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0h", tag, got);
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  op_mode_t   sh_modes [5] = '{SHL, SHR, ROL, ROR, ASR};
  logic [7:0] sh_exp   [5] = '{8'h02, 8'hC0, 8'h03, 8'hC0, 8'hC0};
  logic [7:0] up_exp   [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
  logic       up_wrap  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0;
    mode = HOLD; d = 8'h00; max_val = 8'd5;
    ser_in_l = 1'b1; ser_in_r = 1'b0;
`ifdef UNIV_SHIFT_COUNTER_SAT_EN
    sat = 1'b0;
`endif
    #2;

    // Reset overrides load/en/UP.
    rst = 1'b1; load = 1'b1; d = 8'hAA; en = 1'b1; mode = UP;
    tick();
    check("rst_q", q, 32'h3C);
    check("rst_wrap", wrap, 0);

    // Nothing active: hold.
    idle_inputs();
    tick();
    check("idle_hold", q, 32'h3C);

    // syn_clr goes to 0, not RST_VAL.
    syn_clr = 1'b1;
    tick();
    check("syn_clr_q", q, 0);

    // UP modulo max_val=5.
    idle_inputs(); en = 1'b1; mode = UP; max_val = 8'd5;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("up%0d_q", i), q, up_exp[i]);
      check($sformatf("up%0d_wrap", i), wrap, up_wrap[i]);
      check($sformatf("up%0d_tc", i), tc, (up_exp[i] == 8'd5));
    end

    // DOWN from 0 wraps to max_val.
    idle_inputs(); syn_clr = 1'b1;
    tick();
    idle_inputs(); en = 1'b1; mode = DOWN;
    #1;
    check("down_tc_at0", tc, 1);
    tick();
    check("down_wrap_q", q, 5);
    check("down_wrap_pulse", wrap, 1);
    tick();
    check("down_q4", q, 4);
    check("down_wrap_clear", wrap, 0);

    // Load above max_val, then UP wraps to 0.
    idle_inputs(); load = 1'b1; d = 8'd9;
    tick();
    check("load9_q", q, 9);
    check("load9_wrap", wrap, 0);
    idle_inputs(); en = 1'b1; mode = UP;
    tick();
    check("over_max_q", q, 0);
    check("over_max_wrap", wrap, 1);

    // max_val=0: q stays 0, wrap every enabled cycle.
    max_val = 8'd0;
    tick();
    check("max0_q", q, 0);
    check("max0_wrap", wrap, 1);

    // Free-running wrap at 2^N-1.
    max_val = 8'hFF; idle_inputs(); load = 1'b1; d = 8'hFF;
    tick();
    idle_inputs(); en = 1'b1; mode = UP;
    tick();
    check("free_q", q, 0);
    check("free_wrap", wrap, 1);

    // Shifts and rotates from 8'b1000_0001.
    ser_in_l = 1'b1; ser_in_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); load = 1'b1; d = 8'h81;
      tick();
      check($sformatf("sh%0d_ser_out_l", i), ser_out_l, 1);
      check($sformatf("sh%0d_ser_out_r", i), ser_out_r, 1);
      idle_inputs(); en = 1'b1; mode = sh_modes[i];
      tick();
      check($sformatf("sh%0d_%s_q", i, sh_modes[i].name()), q, sh_exp[i]);
      check($sformatf("sh%0d_wrap", i), wrap, 0);
    end
    check("shl_path_ser_out_r", ser_out_r, 0);

    // HOLD with en.
    mode = HOLD;
    tick();
    check("hold_q", q, 32'hC0);

    // Priority: syn_clr over load over en.
    syn_clr = 1'b1; load = 1'b1; en = 1'b1; mode = UP; d = 8'h55;
    tick();
    check("prio_clr_q", q, 0);
    syn_clr = 1'b0; load = 1'b1; en = 1'b1; mode = UP; d = 8'h10;
    tick();
    check("prio_load_q", q, 32'h10);

    // Reset mid-count, then resume.
    idle_inputs(); en = 1'b1; mode = UP; max_val = 8'hFF;
    tick();
    check("count_11", q, 32'h11);
    rst = 1'b1;
    tick();
    check("midrst_q", q, 32'h3C);
    rst = 1'b0;
    tick();
    check("resume_q", q, 32'h3D);

`ifdef UNIV_SHIFT_COUNTER_SAT_EN
    // Saturating count.
    idle_inputs(); sat = 1'b1; max_val = 8'd3; load = 1'b1; d = 8'd3;
    tick();
    idle_inputs(); en = 1'b1; mode = UP;
    tick();
    check("sat_up_q", q, 3);
    check("sat_up_wrap", wrap, 0);
    idle_inputs(); syn_clr = 1'b1;
    tick();
    idle_inputs(); en = 1'b1; mode = DOWN;
    tick();
    check("sat_down_q", q, 0);
    check("sat_down_wrap", wrap, 0);
    sat = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
